// File: rtl/alu_pkg.sv
// Shared ALU package: divider FSM states and MIN-value helper.
// Ports: none (types and functions only).
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SIGN
  } div_state_t;

  // Most negative w-bit two's-complement value, zero-extended to 64 bits.
  function automatic logic [63:0] min_of(input int w);
    return 64'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/divisor_secuencial_if.sv
// Divider request/result bundle between the ALU and the divider.
// Ports: start/A/B (request), out/rem/overflow/car/busy/done (result).
interface divisor_secuencial_if #(
  parameter int n = 24
);

  logic         start;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic [n-1:0] out;
  logic [n-1:0] rem;
  logic         overflow;
  logic         car;
  logic         busy;
  logic         done;

  modport master (
    output start, A, B,
    input  out, rem, overflow, car, busy, done
  );

  modport slave (
    input  start, A, B,
    output out, rem, overflow, car, busy, done
  );

endinterface

// File: rtl/paso_division.sv
// One combinational restoring-division step on R:Q.
// Ports: r/q/bv in (partial rem, quotient, |B|), r_nx/q_nx out.
module paso_division #(
  parameter int n = 24
) (
  input  logic [n:0]   r,
  input  logic [n-1:0] q,
  input  logic [n-1:0] bv,
  output logic [n:0]   r_nx,
  output logic [n-1:0] q_nx
);

  logic [n+1:0] trial;
  logic         ge;

  // R stays below 2^n, so bit n+1 of the difference is the borrow.
  always_comb begin
    trial = {r, q[n-1]} - {2'b00, bv};
    ge    = ~trial[n+1];
    r_nx  = ge ? trial[n:0] : {r[n-1:0], q[n-1]};
    q_nx  = {q[n-2:0], ge};
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential signed divider, one restoring step per clock.
// Ports: clk, rst (async high), io (slave: start/A/B -> out/rem/flags).
module divisor_secuencial
  import alu_pkg::*;
#(
  parameter int n = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  divisor_secuencial_if.slave  io
);

  localparam int cw = $clog2(n);
  localparam logic [n-1:0] min_val = n'(min_of(n));
  localparam logic [cw-1:0] last = cw'(n - 1);

  div_state_t state, state_nx;

  logic [cw-1:0] cnt;
  logic [n:0]    r, r_nx;
  logic [n-1:0]  q, q_nx, bv;
  logic          sa, sb, dz, mo;

  logic [n-1:0]  abs_a, abs_b;
  logic [n-1:0]  res_out, res_rem;
  logic          res_ovf;

  logic [n-1:0]  out_q, rem_q;
  logic          ovf_q, done_q;

  // |MIN| wraps to 2^(n-1), which reads correctly as unsigned.
  assign abs_a = io.A[n-1] ? -io.A : io.A;
  assign abs_b = io.B[n-1] ? -io.B : io.B;

  paso_division #(.n(n)) u_paso (
    .r    (r),
    .q    (q),
    .bv   (bv),
    .r_nx (r_nx),
    .q_nx (q_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (io.start) state_nx = DIV;
      DIV:     if (cnt == last) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With B==0 every step subtracts nothing, so R ends at |A|
  // and the signed remainder below reproduces A unchanged.
  always_comb begin
    res_out = (sa ^ sb) ? -q : q;
    res_rem = sa ? -r[n-1:0] : r[n-1:0];
    res_ovf = 1'b0;
    if (dz) begin
      res_out = '0;
      res_ovf = 1'b1;
    end else if (mo) begin
      res_out = min_val;
      res_rem = '0;
      res_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      r      <= '0;
      q      <= '0;
      bv     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      mo     <= 1'b0;
      out_q  <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == SIGN);
      unique case (state)
        IDLE: begin
          if (io.start) begin
            sa  <= io.A[n-1];
            sb  <= io.B[n-1];
            q   <= abs_a;
            bv  <= abs_b;
            r   <= '0;
            cnt <= '0;
            dz  <= (io.B == '0);
            mo  <= (io.A == min_val) && (io.B == '1);
          end
        end
        DIV: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
        end
        SIGN: begin
          out_q <= res_out;
          rem_q <= res_rem;
          ovf_q <= res_ovf;
        end
        default: ;
      endcase
    end
  end

  assign io.out      = out_q;
  assign io.rem      = rem_q;
  assign io.overflow = ovf_q;
  assign io.car      = 1'b0;
  assign io.busy     = (state != IDLE);
  assign io.done     = done_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial (n=24).
// Directed plan cases plus random operands vs. an arithmetic model.
module tb_divisor_secuencial;

  localparam int n = 24;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  divisor_secuencial_if #(.n(n)) dif ();

  divisor_secuencial #(.n(n)) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [n-1:0] obs,
                     input logic [n-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division from plain arithmetic.
  function automatic void model(input  logic [n-1:0] a,
                                input  logic [n-1:0] b,
                                output logic [n-1:0] q,
                                output logic [n-1:0] r,
                                output logic         ov);
    longint ai, bi, qi, ri;
    ai = longint'($signed(a));
    bi = longint'($signed(b));
    if (bi == 0) begin
      q = '0; r = a; ov = 1'b1;
    end else if (ai == -(longint'(1) << (n - 1)) && bi == -1) begin
      q = a; r = '0; ov = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q = qi[n-1:0];
      r = ri[n-1:0];
      ov = 1'b0;
    end
  endfunction

  // Called just after a negedge; returns just after the start edge.
  task automatic launch(input logic [n-1:0] a, input logic [n-1:0] b);
    dif.A = a;
    dif.B = b;
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.A = n'($urandom);
    dif.B = n'($urandom);
  endtask

  // lat counts rising edges since the start edge; bounded wait.
  task automatic wait_done(input string tag, input int from,
                           input logic [n-1:0] a,
                           input logic [n-1:0] b);
    int lat;
    logic [n-1:0] qe, re;
    logic ov;
    lat = from;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) chk({tag, " busy"}, n'(dif.busy), n'(1));
      if (dif.done) break;
    end
    chk({tag, " lat"}, n'(lat), n'(n + 1));
    model(a, b, qe, re, ov);
    chk({tag, " out"}, dif.out, qe);
    chk({tag, " rem"}, dif.rem, re);
    chk({tag, " ovf"}, n'(dif.overflow), n'(ov));
    chk({tag, " car"}, n'(dif.car), n'(0));
    chk({tag, " idle"}, n'(dif.busy), n'(0));
  endtask

  initial begin
    logic [n-1:0] a, b;
    logic seen;
    int sel;

    rst = 1'b1;
    dif.start = 1'b0;
    dif.A = '0;
    dif.B = '0;
    @(negedge clk);
    chk("rst out", dif.out, '0);
    chk("rst rem", dif.rem, '0);
    chk("rst ovf", n'(dif.overflow), '0);
    chk("rst busy", n'(dif.busy), '0);
    chk("rst done", n'(dif.done), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    launch(24'd100, 24'd7);
    wait_done("100/7", 0, 24'd100, 24'd7);
    chk("100/7 lit", dif.out, 24'd14);
    launch(-24'd100, 24'd7);
    wait_done("-100/7", 0, -24'd100, 24'd7);
    chk("-100/7 lit", dif.rem, 24'hFFFFFE);
    launch(24'd100, -24'd7);
    wait_done("100/-7", 0, 24'd100, -24'd7);
    launch(24'd7, 24'd0);
    wait_done("7/0", 0, 24'd7, 24'd0);
    launch(24'h800000, 24'hFFFFFF);
    wait_done("min/-1", 0, 24'h800000, 24'hFFFFFF);
    chk("min/-1 lit", dif.out, 24'h800000);

    // Re-pulse start while busy: must be ignored.
    launch(24'd50, 24'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.start = 1'b1;
    dif.A = 24'd9;
    dif.B = 24'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done("50/5", 10, 24'd50, 24'd5);
    // Start in the done cycle.
    launch(24'd9, 24'd3);
    wait_done("9/3", 0, 24'd9, 24'd3);

    // Reset mid-DIV.
    launch(24'd1000, 24'd3);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst out", dif.out, '0);
    chk("mid rst rem", dif.rem, '0);
    chk("mid rst busy", n'(dif.busy), '0);
    chk("mid rst done", n'(dif.done), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (dif.done) seen = 1'b1;
    end
    chk("no done", n'(seen), '0);
    launch(24'd1000, 24'd3);
    wait_done("1000/3", 0, 24'd1000, 24'd3);

    for (int i = 0; i < 24; i++) begin
      a = n'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin
        a = 24'h800000;
        b = '1;
      end else if (sel == 2) begin
        b = n'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end else b = n'($urandom);
      launch(a, b);
      wait_done($sformatf("rnd%0d", i), 0, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Sequential signed integer divider for the processor ALU; the inverse of the combinational multiplier. It accepts two signed n-bit operands on a start pulse and runs one restoring-division step per clock. It returns a truncated quotient and a remainder with the dividend's sign, plus overflow/carry flags in the ALU flag format. The ALU holds the pipeline on `busy` and latches results on `done`.

## Interface
- `n`, 24, operand/result width in bits (n ≥ 4)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `A`  in  n  signed dividend
- `B`  in  n  signed divisor
- `out`  out  n  signed quotient, truncated toward zero
- `rem`  out  n  signed remainder, same sign as `A` (or zero)
- `overflow`  out  1  divide-by-zero or MIN/−1
- `car`  out  1  carry flag, tied 0 (ALU flag format)
- `busy`  out  1  high in DIV and SIGN
- `done`  out  1  one-cycle result-valid pulse

One clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, DIV, SIGN.
- **IDLE with `start`=1:**
  - Capture the sign of `A` and the sign of `B`.
  - Capture |A| and |B| as n-bit unsigned. |MIN| = 2^(n-1) fits.
  - Capture the flags `dz` = (B==0) and `mo` = (A==MIN && B==−1).
  - Clear the partial remainder and set the step counter to 0.
  - Go to DIV.
- **DIV, each cycle:** one restoring step on (n+1)-bit partial remainder R and n-bit quotient shift register Q:
  - Shift R:Q left by 1.
  - Trial = R − |B|.
  - If trial ≥ 0: R = trial, Q[0] = 1; otherwise Q[0] = 0.
  - After step n−1 (counter == n−1), go to SIGN.
  - DIV always runs the full n cycles, including the `dz`/`mo` cases; latency is fixed.
- **SIGN, one cycle:**
  - Normal case: `out` = Q, negated if sign(A) ≠ sign(B); `rem` = R[n-1:0], negated if sign(A) = 1; `overflow` = 0.
  - `dz`: `out` = 0, `rem` = A, `overflow` = 1.
  - `mo`: `out` = MIN (2^(n-1) wrapped), `rem` = 0, `overflow` = 1.
  - Assert `done` (registered) and return to IDLE.
- `out`, `rem`, `overflow` are registered and hold until the next SIGN cycle.
- `start` while `busy` is ignored. Operands are not re-sampled.
- `car` is constant 0.

## Timing
- Reset values: `out`=0, `rem`=0, `overflow`=0, `car`=0, `busy`=0, `done`=0; state IDLE; counter 0.
- `start` sampled at edge 0:
  - `busy` is high from after edge 0 through edge n+1.
  - `done` and the new results are visible after edge n+1, for exactly one cycle. Start-to-done latency is n+1 cycles (25 for n=24).
- `done` and IDLE coincide. A `start` in the `done` cycle is accepted, so the back-to-back throughput is one result per n+1 cycles.
- `rst` at any time, including mid-DIV, forces the reset values immediately. The aborted operation produces no `done`.
- `A`/`B` may change freely after the start edge.

## Structure
- Shared package `alu_pkg`:
  - `typedef enum logic [1:0] {IDLE, DIV, SIGN} div_state_t`
  - Localparam helper for MIN (`{1'b1,{(n-1){1'b0}}}`) as a function of n.
- Sub-module `paso_division`: purely combinational, one restoring step. Inputs are R, Q and |B|; outputs are the next R and next Q.
- The top level holds the FSM, counter ($clog2(n) bits), sign/flag capture and the SIGN stage.

## Test plan
- A=100, B=7, start → after 25 cycles `done`=1, `out`=14, `rem`=2, `overflow`=0, `car`=0.
- A=−100, B=7 → `out`=−14 (0xFFFFF2), `rem`=−2 (0xFFFFFE). Repeat with A=100, B=−7 → `out`=−14, `rem`=2.
- A=7, B=0 → `done` at cycle 25, `out`=0, `rem`=7, `overflow`=1.
- A=0x800000, B=−1 (0xFFFFFF) → `out`=0x800000, `rem`=0, `overflow`=1.
- Start with A=50, B=5; re-pulse `start` with A=9, B=3 at cycle 10 → ignored; `done` at cycle 25 with `out`=10, `rem`=0. A start in the `done` cycle with 9/3 → second `done` 25 cycles later with `out`=3.
- Start 1000/3; assert `rst` at cycle 12 → all outputs 0 immediately, no `done` afterward; a new start of 1000/3 after release → `out`=333, `rem`=1.
